// File: rtl/riscv_muldiv.sv
// rtl/riscv_muldiv.sv - iterative RV32M/RV64M multiply/divide unit
// Shift-add multiply and restoring divide, one bit per cycle, on operand magnitudes.
module riscv_muldiv #(
   parameter int XLEN = 32,
   localparam int CNTW = $clog2(XLEN + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t              state_q, state_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic [XLEN:0]       rem_q, rem_d;
   logic                neg_q, neg_d;
   logic                spec_q, spec_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                sign_a, sign_b, div_zero, div_ovf;
   logic [XLEN-1:0]     a_mag, b_mag, quot, remv;
   logic [XLEN:0]       sum, shifted, diff;
   logic [2*XLEN-1:0]   prod_fix;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      prod_d   = prod_q;
      rem_d    = rem_q;
      neg_d    = neg_q;
      spec_d   = spec_q;
      result_d = result_q;
      done_d   = 1'b0;

      sign_a   = rs1[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                (funct3 == 3'b100) | (funct3 == 3'b110));
      sign_b   = rs2[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                                (funct3 == 3'b110));
      a_mag    = sign_a ? -rs1 : rs1;
      b_mag    = sign_b ? -rs2 : rs2;
      div_zero = funct3[2] & (rs2 == '0);
      div_ovf  = ((funct3 == 3'b100) | (funct3 == 3'b110)) &
                 (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);

      sum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
      shifted  = {rem_q[XLEN-1:0], prod_q[XLEN-1]};
      diff     = shifted - {1'b0, opnd_q};
      prod_fix = neg_q ? -prod_q : prod_q;
      quot     = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
      remv     = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               op_d  = funct3;
               cnt_d = '0;
               rem_d = '0;
               // Remainder sign follows the dividend only; everything else uses signA^signB.
               neg_d = (funct3[2] & funct3[1]) ? sign_a : (sign_a ^ sign_b);
               if (div_zero || div_ovf) begin
                  // Special results are precomputed here and simply published in FIN.
                  spec_d  = 1'b1;
                  opnd_d  = '0;
                  state_d = S_FIN;
                  if (div_zero)
                     prod_d = {{XLEN{1'b0}}, funct3[1] ? rs1 : {XLEN{1'b1}}};
                  else
                     prod_d = {{XLEN{1'b0}}, funct3[1] ? {XLEN{1'b0}} : rs1};
               end else begin
                  spec_d  = 1'b0;
                  state_d = S_CALC;
                  prod_d  = {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
                  opnd_d  = funct3[2] ? b_mag : a_mag;
               end
            end
         end
         S_CALC: begin
            if (op_q[2]) begin
               if (!diff[XLEN]) begin
                  rem_d  = diff;
                  prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_d  = shifted;
                  prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], 1'b0};
               end
            end else begin
               prod_d = {sum, prod_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(XLEN - 1))
               state_d = S_FIN;
         end
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (spec_q)
               result_d = prod_q[XLEN-1:0];
            else begin
               case (op_q)
                  3'b000:                 result_d = prod_fix[XLEN-1:0];
                  3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
                  3'b100, 3'b101:         result_d = quot;
                  default:                result_d = remv;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over both a new request and completion.
      if (flush) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         result_d = result_q;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         neg_q    <= 1'b0;
         spec_q   <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         prod_q   <= prod_d;
         rem_q    <= rem_d;
         neg_q    <= neg_d;
         spec_q   <= spec_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// tb/tb_riscv_muldiv.sv - directed self-checking bench for riscv_muldiv
module tb_riscv_muldiv;

   logic        clk;
   logic        reset;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp;
   int n_bad;

   riscv_muldiv #(.XLEN(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .rs1    (rs1),
      .rs2    (rs2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issues one op; inj>0 pulses a stray start that many edges after E0.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int inj, input bit aligned);
      int lat;
      int busy_n;
      bit got_done;
      if (!aligned) @(negedge clk);
      funct3 = f;
      rs1    = a;
      rs2    = b;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      lat      = 0;
      busy_n   = busy ? 1 : 0;
      got_done = 1'b0;
      while (lat < 100 && !got_done) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == inj) begin
            start  = 1'b1;
            funct3 = 3'b100;
            rs1    = 32'h0000_1234;
            rs2    = 32'h0000_0005;
         end else begin
            start = 1'b0;
         end
         if (busy) busy_n++;
         if (done) got_done = 1'b1;
      end
      check_eq({tag, "_done"}, 64'(got_done), 64'd1);
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_busy"}, 64'(busy_n), 64'(exp_lat));
      check_eq({tag, "_res"}, 64'(result), 64'(exp_res));
   endtask

   initial begin
      int seen;
      n_cmp  = 0;
      n_bad  = 0;
      reset  = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = 3'b000;
      rs1    = '0;
      rs2    = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_res", 64'(result), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, 1'b0);
      run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0, 1'b0);
      run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, 1'b0);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 1'b0);
      run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 0, 1'b0);
      run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 0, 1'b0);
      run_op("divu",   3'b101, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, 33, 0, 1'b0);
      run_op("remu",   3'b111, 32'd10,       32'd3,        32'd1,         33, 0, 1'b0);

      run_op("div_z",  3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1, 0, 1'b0);
      run_op("remu_z", 3'b111, 32'd5,        32'd0,        32'd5,         1, 0, 1'b0);
      run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 1'b0);
      run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1, 0, 1'b0);

      run_op("ign_start", 3'b000, 32'd6, 32'd7, 32'd42, 33, 10, 1'b0);

      run_op("b2b_1", 3'b000, 32'd2,   32'd3, 32'd6,  33, 0, 1'b0);
      run_op("b2b_2", 3'b101, 32'd100, 32'd7, 32'd14, 33, 0, 1'b1);

      // Flush at CALC cycle 10: no done, previous result held.
      @(negedge clk);
      funct3 = 3'b000;
      rs1    = 32'd5;
      rs2    = 32'd5;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_eq("flush_busy", 64'(busy), 64'd0);
      check_eq("flush_done", 64'(done), 64'd0);
      check_eq("flush_res", 64'(result), 64'd14);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check_eq("flush_nodone", 64'(seen), 64'd0);

      // Flush in IDLE suppresses a simultaneous start.
      start = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check_eq("idle_flush", 64'(busy), 64'd0);

      // Asynchronous reset between edges mid-CALC.
      @(negedge clk);
      funct3 = 3'b000;
      rs1    = 32'd9;
      rs2    = 32'd9;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_eq("arst_busy", 64'(busy), 64'd0);
      check_eq("arst_done", 64'(done), 64'd0);
      check_eq("arst_res", 64'(result), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("post_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
